snake_step_engine: RTL and testbench



---
 rtl/snake_pkg.sv | 38 +++
 rtl/snake_body_fifo.sv | 56 +++++
 rtl/snake_step_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_snake_step_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared cell codes, direction/state enums and food LFSR for the snake engine
package snake_pkg;

    localparam logic [2:0] CELL_EMPTY = 3'd0;
    localparam logic [2:0] CELL_BODY  = 3'd1;
    localparam logic [2:0] CELL_FOOD  = 3'd2;
    localparam logic [2:0] CELL_WALL  = 3'd4;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [3:0] {
        ST_CLEAR,
        ST_DRAW,
        ST_FOOD_GEN,
        ST_FOOD_RD,
        ST_FOOD_CHK,
        ST_IDLE,
        ST_HEAD_RD,
        ST_HEAD_CHK,
        ST_HEAD_WR,
        ST_TAIL_WR,
        ST_DEAD
    } state_t;

    // x^16+x^14+x^13+x^11 in right-shifting Fibonacci form: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// rtl/snake_body_fifo.sv - circular buffer of snake cell addresses, head pushed, tail popped
module snake_body_fifo #(
    parameter int MAX_LEN    = 64,
    parameter int ADDR_WIDTH = 11,
    parameter int INIT_LEN   = 3
) (
    input  logic                  i_clk,
    input  logic                  rstn,
    input  logic                  i_init,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [ADDR_WIDTH-1:0] o_tail,
    output logic [6:0]            o_len
);

    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [ADDR_WIDTH-1:0] mem [MAX_LEN];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == MAX_LEN - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_init || i_push) begin
            mem[wr_ptr] <= i_addr;
        end
    end

    // Initial body cells are loaded without counting: length already reads INIT_LEN from reset
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_len  <= 7'(INIT_LEN);
        end else begin
            if (i_init || i_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (i_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (i_push && !i_pop) begin
                o_len <= o_len + 1'b1;
            end else if (i_pop && !i_push) begin
                o_len <= o_len - 1'b1;
            end
        end
    end

    assign o_tail = mem[rd_ptr];

endmodule

// File: rtl/snake_step_engine.sv
// rtl/snake_step_engine.sv - snake board writer: clear, draw, food placement and per-tick step
// Optional SNAKE_WRAP_EN: heads leaving the grid wrap around instead of killing the snake.
module snake_step_engine
    import snake_pkg::*;
#(
    parameter int GRID_W     = 80,
    parameter int GRID_H     = 25,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 3,
    parameter int MAX_LEN    = 64,
    parameter int INIT_LEN   = 3
) (
    input  logic                  i_clk,
    input  logic                  rstn,
    input  logic                  i_tick,
    input  logic [1:0]            i_dir,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_write,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_busy,
    output logic                  o_grow,
    output logic                  o_dead,
    output logic [6:0]            o_len
);

    localparam int X_W   = $clog2(GRID_W);
    localparam int Y_W   = $clog2(GRID_H);
    localparam int CELLS = GRID_W * GRID_H;
    localparam logic [ADDR_WIDTH-1:0] DRAW_BASE = ADDR_WIDTH'((GRID_H / 2) * GRID_W + 10);
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [DATA_WIDTH-1:0] D_EMPTY = DATA_WIDTH'(CELL_EMPTY);
    localparam logic [DATA_WIDTH-1:0] D_BODY  = DATA_WIDTH'(CELL_BODY);
    localparam logic [DATA_WIDTH-1:0] D_FOOD  = DATA_WIDTH'(CELL_FOOD);

    state_t                state;
    dir_t                  dir;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [15:0]           lfsr;
    logic [X_W-1:0]        head_x, nxt_x;
    logic [Y_W-1:0]        head_y, nxt_y;
    logic                  grow;

    dir_t                  acc_dir;
    logic [X_W-1:0]        nx;
    logic [Y_W-1:0]        ny;
    logic                  off_grid;
    logic [ADDR_WIDTH-1:0] n_addr;
    logic [ADDR_WIDTH-1:0] cand_addr;
    logic                  cand_ok;
    logic [ADDR_WIDTH-1:0] tail_addr;
    logic                  rd_fatal;

    // A request for the exact reverse direction is ignored; the snake keeps its heading
    always_comb begin
        acc_dir  = (i_dir == (dir ^ 2'd2)) ? dir : dir_t'(i_dir);
        nx       = head_x;
        ny       = head_y;
        off_grid = 1'b0;
        case (acc_dir)
            DIR_UP: begin
                if (head_y == '0) begin
                    ny       = Y_W'(GRID_H - 1);
                    off_grid = 1'b1;
                end else begin
                    ny = head_y - 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (int'(head_x) == GRID_W - 1) begin
                    nx       = '0;
                    off_grid = 1'b1;
                end else begin
                    nx = head_x + 1'b1;
                end
            end
            DIR_DOWN: begin
                if (int'(head_y) == GRID_H - 1) begin
                    ny       = '0;
                    off_grid = 1'b1;
                end else begin
                    ny = head_y + 1'b1;
                end
            end
            default: begin
                if (head_x == '0) begin
                    nx       = X_W'(GRID_W - 1);
                    off_grid = 1'b1;
                end else begin
                    nx = head_x - 1'b1;
                end
            end
        endcase
    end

    assign n_addr    = ADDR_WIDTH'(ny) * ADDR_WIDTH'(GRID_W) + ADDR_WIDTH'(nx);
    assign cand_ok   = (int'(lfsr[6:0]) < GRID_W) && (int'(lfsr[11:7]) < GRID_H);
    assign cand_addr = ADDR_WIDTH'(lfsr[11:7]) * ADDR_WIDTH'(GRID_W) + ADDR_WIDTH'(lfsr[6:0]);
    assign rd_fatal  = (i_rdata != D_EMPTY) && (i_rdata != D_FOOD);

    snake_body_fifo #(
        .MAX_LEN    (MAX_LEN),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_LEN   (INIT_LEN)
    ) u_body (
        .i_clk  (i_clk),
        .rstn   (rstn),
        .i_init (state == ST_DRAW),
        .i_push (state == ST_HEAD_WR),
        .i_pop  ((state == ST_HEAD_WR) && !grow),
        .i_addr ((state == ST_DRAW) ? (DRAW_BASE + cnt) : o_addr),
        .o_tail (tail_addr),
        .o_len  (o_len)
    );

    // Outputs are registered on the transition into the state that owns the RAM access
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_CLEAR;
            dir     <= DIR_RIGHT;
            cnt     <= '0;
            lfsr    <= LFSR_SEED;
            head_x  <= X_W'(10 + INIT_LEN - 1);
            head_y  <= Y_W'(GRID_H / 2);
            nxt_x   <= '0;
            nxt_y   <= '0;
            grow    <= 1'b0;
            o_addr  <= '0;
            o_write <= 1'b0;
            o_data  <= '0;
            o_busy  <= 1'b1;
            o_grow  <= 1'b0;
            o_dead  <= 1'b0;
        end else begin
            o_write <= 1'b0;
            o_grow  <= 1'b0;
            o_busy  <= 1'b1;
            case (state)
                ST_CLEAR: begin
                    o_addr  <= cnt;
                    o_data  <= D_EMPTY;
                    o_write <= 1'b1;
                    if (int'(cnt) == CELLS - 1) begin
                        cnt   <= '0;
                        state <= ST_DRAW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DRAW: begin
                    o_addr  <= DRAW_BASE + cnt;
                    o_data  <= D_BODY;
                    o_write <= 1'b1;
                    if (int'(cnt) == INIT_LEN - 1) begin
                        cnt    <= '0;
                        dir    <= DIR_RIGHT;
                        head_x <= X_W'(10 + INIT_LEN - 1);
                        head_y <= Y_W'(GRID_H / 2);
                        state  <= ST_FOOD_GEN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FOOD_GEN: begin
                    lfsr <= lfsr_next(lfsr);
                    if (cand_ok) begin
                        o_addr <= cand_addr;
                        state  <= ST_FOOD_RD;
                    end
                end
                ST_FOOD_RD: state <= ST_FOOD_CHK;
                ST_FOOD_CHK: begin
                    if (i_rdata == D_EMPTY) begin
                        o_data  <= D_FOOD;
                        o_write <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        state <= ST_FOOD_GEN;
                    end
                end
                ST_IDLE: begin
                    if (i_tick) begin
                        dir <= acc_dir;
                        if (off_grid && !WRAP) begin
                            o_dead <= 1'b1;
                            state  <= ST_DEAD;
                        end else begin
                            o_addr <= n_addr;
                            nxt_x  <= nx;
                            nxt_y  <= ny;
                            state  <= ST_HEAD_RD;
                        end
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                ST_HEAD_RD: state <= ST_HEAD_CHK;
                ST_HEAD_CHK: begin
                    if (rd_fatal) begin
                        o_dead <= 1'b1;
                        state  <= ST_DEAD;
                    end else begin
                        grow    <= (i_rdata == D_FOOD) && (int'(o_len) < MAX_LEN);
                        o_data  <= D_BODY;
                        o_write <= 1'b1;
                        state   <= ST_HEAD_WR;
                    end
                end
                ST_HEAD_WR: begin
                    head_x <= nxt_x;
                    head_y <= nxt_y;
                    if (grow) begin
                        o_grow <= 1'b1;
                        state  <= ST_FOOD_GEN;
                    end else begin
                        o_addr  <= tail_addr;
                        o_data  <= D_EMPTY;
                        o_write <= 1'b1;
                        state   <= ST_TAIL_WR;
                    end
                end
                ST_TAIL_WR: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_DEAD: o_dead <= 1'b1;
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_step_engine.sv
// tb/tb_snake_step_engine.sv - scoreboard bench for snake_step_engine with a board RAM model
module tb_snake_step_engine;
    import snake_pkg::*;

    logic        i_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_tick = 1'b0;
    logic [1:0]  i_dir = 2'd1;
    logic [10:0] o_addr;
    logic        o_write;
    logic [2:0]  o_data;
    logic [2:0]  i_rdata = 3'd0;
    logic        o_busy, o_grow, o_dead;
    logic [6:0]  o_len;

    snake_step_engine dut (
        .i_clk   (i_clk),
        .rstn    (rstn),
        .i_tick  (i_tick),
        .i_dir   (i_dir),
        .o_addr  (o_addr),
        .o_write (o_write),
        .o_data  (o_data),
        .i_rdata (i_rdata),
        .o_busy  (o_busy),
        .o_grow  (o_grow),
        .o_dead  (o_dead),
        .o_len   (o_len)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int addr;
        int data;
        bit any;
    } wr_t;

    wr_t         exp_q[$];
    int          bq[$];
    int          total = 0;
    int          bad = 0;
    int          grow_seen = 0;
    int          hx, hy, hdir;
    logic [2:0]  mem [2048];
    logic        poke_en = 1'b0;
    logic [10:0] poke_addr = '0;
    logic [2:0]  poke_val = '0;

    // FOOD is stored as EMPTY so stray food never changes a later step; targets are injected
    always @(posedge i_clk) begin
        if (o_write) mem[o_addr] <= (o_data == CELL_FOOD) ? CELL_EMPTY : o_data;
        i_rdata <= (poke_en && o_addr == poke_addr) ? poke_val : mem[o_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        wr_t e;
        forever begin
            @(negedge i_clk);
            if (rstn && o_grow) grow_seen++;
            if (rstn && o_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", int'(o_addr), -1);
                end else begin
                    e = exp_q.pop_front();
                    if (e.any) begin
                        check("food_data", int'(o_data), int'(CELL_FOOD));
                        check("food_target_empty", int'(mem[o_addr]), int'(CELL_EMPTY));
                        check("food_in_grid", int'(o_addr < 11'd2000), 1);
                    end else begin
                        check("wr_addr", int'(o_addr), e.addr);
                        check("wr_data", int'(o_data), e.data);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (o_busy && n < max) begin
            @(negedge i_clk);
            n++;
        end
        check(name, int'(o_busy), 0);
    endtask

    task automatic tick_cycle(input int d);
        i_dir = 2'(d);
        i_tick = 1'b1;
        @(negedge i_clk);
        i_tick = 1'b0;
    endtask

    task automatic push_startup();
        for (int a = 0; a < 2000; a++) exp_q.push_back('{a, 0, 1'b0});
        for (int i = 0; i < 3; i++) exp_q.push_back('{970 + i, 1, 1'b0});
        exp_q.push_back('{0, 2, 1'b1});
    endtask

    task automatic startup();
        push_startup();
        rstn = 1'b1;
        wait_idle(6000, "startup_idle");
        check("startup_drained", exp_q.size(), 0);
        check("startup_len", int'(o_len), 3);
        check("startup_alive", int'(o_dead), 0);
        bq.delete();
        for (int i = 0; i < 3; i++) bq.push_back(970 + i);
        hx = 12;
        hy = 12;
        hdir = 1;
    endtask

    task automatic do_step(input int d, input bit food, input bit extra);
        int nx, ny, na, g0;
        if (d != (hdir ^ 2)) hdir = d;
        nx = hx;
        ny = hy;
        case (hdir)
            0: ny = (hy + 24) % 25;
            1: nx = (hx + 1) % 80;
            2: ny = (hy + 1) % 25;
            default: nx = (hx + 79) % 80;
        endcase
        na = ny * 80 + nx;
        exp_q.push_back('{na, 1, 1'b0});
        if (food) begin
            exp_q.push_back('{0, 2, 1'b1});
            poke_addr = 11'(na);
            poke_val = CELL_FOOD;
            poke_en = 1'b1;
        end else begin
            exp_q.push_back('{bq.pop_front(), 0, 1'b0});
        end
        bq.push_back(na);
        g0 = grow_seen;
        tick_cycle(d);
        check("rd_addr", int'(o_addr), na);
        check("rd_nowrite", int'(o_write), 0);
        if (!food) begin
            if (extra) tick_cycle(2);
            else @(negedge i_clk);
            repeat (2) @(negedge i_clk);
            check("busy_t4", int'(o_busy), 1);
            @(negedge i_clk);
            check("idle_t5", int'(o_busy), 0);
        end
        wait_idle(3000, "step_idle");
        poke_en = 1'b0;
        check("grow_pulses", grow_seen - g0, int'(food));
        check("len", int'(o_len), bq.size());
        hx = nx;
        hy = ny;
    endtask

    initial begin
        @(negedge i_clk);
        check("rst_addr", int'(o_addr), 0);
        check("rst_write", int'(o_write), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_busy", int'(o_busy), 1);
        check("rst_grow", int'(o_grow), 0);
        check("rst_dead", int'(o_dead), 0);
        check("rst_len", int'(o_len), 3);

        push_startup();
        rstn = 1'b1;
        repeat (100) @(negedge i_clk);
        rstn = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        check("midclear_rst_busy", int'(o_busy), 1);
        check("midclear_rst_write", int'(o_write), 0);
        startup();

        do_step(1, 1'b0, 1'b0);
        do_step(1, 1'b1, 1'b0);
        check("grown_len", int'(o_len), 4);
        do_step(3, 1'b0, 1'b1);
        repeat (10) @(negedge i_clk);
        check("no_extra_step_busy", int'(o_busy), 0);
        check("no_extra_step_q", exp_q.size(), 0);

        while (hx < 79) do_step(1, 1'b0, 1'b0);
`ifdef SNAKE_WRAP_EN
        do_step(1, 1'b0, 1'b0);
        check("wrap_x", hx, 0);
        check("wrap_alive", int'(o_dead), 0);
`else
        tick_cycle(1);
        check("edge_dead", int'(o_dead), 1);
        check("edge_nowrite", int'(o_write), 0);
        repeat (6) @(negedge i_clk);
        tick_cycle(1);
        repeat (6) @(negedge i_clk);
        check("edge_dead_sticky", int'(o_dead), 1);
        check("edge_busy", int'(o_busy), 1);
`endif
        check("edge_q_empty", exp_q.size(), 0);

        rstn = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        check("rerst_dead", int'(o_dead), 0);
        check("rerst_len", int'(o_len), 3);
        startup();

        poke_addr = 11'd973;
        poke_val = CELL_WALL;
        poke_en = 1'b1;
        tick_cycle(1);
        check("wall_rd_addr", int'(o_addr), 973);
        repeat (2) @(negedge i_clk);
        check("wall_dead", int'(o_dead), 1);
        poke_en = 1'b0;
        tick_cycle(1);
        repeat (8) @(negedge i_clk);
        check("wall_dead_sticky", int'(o_dead), 1);
        check("wall_busy", int'(o_busy), 1);
        check("wall_len", int'(o_len), 3);
        check("final_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
